// File: rtl/mips_fetch_if.sv
// Bus between the MIPS fetch unit, its instruction block memory and the
// downstream control unit / datapath.
interface mips_fetch_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  Stall;
    logic                  BranchTaken;
    logic [15:0]           BranchOffset;
    logic                  MemEn;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [31:0]           MemData;
    logic [31:0]           Instr;
    logic [5:0]            Opcode;
    logic                  InstrValid;
    logic [31:0]           PC;

    modport master (
        input  Stall, BranchTaken, BranchOffset, MemData,
        output MemEn, MemAddr, Instr, Opcode, InstrValid, PC
    );

    modport slave (
        output Stall, BranchTaken, BranchOffset, MemData,
        input  MemEn, MemAddr, Instr, Opcode, InstrValid, PC
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: holds the PC, reads a 1-cycle-latency block
// memory and presents the instruction register to the control unit.
module mips_fetch_unit #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic           CLK,
    input logic           Reset,
    mips_fetch_if.master  bus
);

    // One-hot so that MemEn and InstrValid are single register bits.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FETCH = 4'b0010,
        WAIT  = 4'b0100,
        ISSUE = 4'b1000
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] pcQ;
    logic [31:0] instrQ;
    logic        memEn;
    logic        instrValid;

    function automatic logic [31:0] branchTarget(input logic [31:0] pc,
                                                 input logic [15:0] offset);
        logic signed [31:0] offsetBytes;
        offsetBytes = {{14{offset[15]}}, offset, 2'b00};
        return pc + 32'd4 + offsetBytes;
    endfunction

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState  = state;
        memEn      = 1'b0;
        instrValid = 1'b0;
        unique case (state)
            IDLE:  nextState = FETCH;
            FETCH: begin
                memEn     = 1'b1;
                nextState = WAIT;
            end
            WAIT:  nextState = ISSUE;
            ISSUE: begin
                instrValid = 1'b1;
                if (!bus.Stall) nextState = FETCH;
            end
            default: nextState = IDLE;
        endcase
    end

    // Instruction capture and PC update; a reset during WAIT drops the read.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pcQ    <= RESET_PC;
            instrQ <= 32'd0;
        end else begin
            if (state == WAIT) instrQ <= bus.MemData;
            if (state == ISSUE && !bus.Stall) begin
                if (bus.BranchTaken) pcQ <= branchTarget(pcQ, bus.BranchOffset);
                else                 pcQ <= pcQ + 32'd4;
            end
        end
    end

    assign bus.MemEn      = memEn;
    assign bus.MemAddr    = pcQ[ADDR_WIDTH+1:2];
    assign bus.Instr      = instrQ;
    assign bus.Opcode     = instrQ[31:26];
    assign bus.InstrValid = instrValid;
    assign bus.PC         = pcQ;

endmodule
